// File: rtl/fifo_pkg.sv
// Shared types and parameter helpers for the width-conversion FIFO read path.
package fifo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } downsize_state_t;

  localparam int DEF_WIDE_WIDTH = 16;
  localparam int DEF_RATIO      = 2;

  // Legal only when the wide word splits exactly into RATIO narrow slices.
  function automatic bit downsize_cfg_ok(input int wide_w, input int ratio, input int narrow_w);
    return (ratio >= 2) && (narrow_w > 0) && (wide_w == ratio * narrow_w);
  endfunction

endpackage

// File: rtl/fifo_downsize_sequencer.sv
// Pops one wide FIFO word and streams it out as RATIO narrow slices, LSB slice first.
// One cycle from non-empty to first valid slice; reload on last accept gives no bubble.
module fifo_downsize_sequencer
  import fifo_pkg::*;
#(
  parameter int WIDE_WIDTH   = DEF_WIDE_WIDTH,
  parameter int RATIO        = DEF_RATIO,
  parameter int NARROW_WIDTH = WIDE_WIDTH / RATIO
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    fifo_empty_i,
  input  logic [WIDE_WIDTH-1:0]   fifo_rd_data_i,
  output logic                    fifo_read_o,
  output logic [NARROW_WIDTH-1:0] out_data_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    out_last_o
);

  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  generate
    if (!downsize_cfg_ok(WIDE_WIDTH, RATIO, NARROW_WIDTH)) begin : g_bad_cfg
      $error("fifo_downsize_sequencer: WIDE_WIDTH must equal RATIO*NARROW_WIDTH with RATIO>=2");
    end
  endgenerate

  downsize_state_t                       state_q, state_d;
  logic [IDX_W-1:0]                      idx_q, idx_d;
  logic [RATIO-1:0][NARROW_WIDTH-1:0]    buf_q, buf_d;

  logic accept;
  logic at_last;
  logic load;

  always_comb begin
    accept  = (state_q == SEND) && out_ready_i;
    at_last = (idx_q == LAST_IDX);
    // A load in IDLE or on the final accept is the only moment a word is popped.
    load    = !fifo_empty_i && ((state_q == IDLE) || (accept && at_last));

    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;

    if (load) begin
      buf_d   = fifo_rd_data_i;
      idx_d   = '0;
      state_d = SEND;
    end else if (accept) begin
      if (at_last) begin
        state_d = IDLE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  assign fifo_read_o = !reset_i && load;
  assign out_valid_o = (state_q == SEND);
  assign out_last_o  = (state_q == SEND) && at_last;
  assign out_data_o  = buf_q[idx_q];

endmodule

// File: tb/tb_fifo_downsize_sequencer.sv
// Randomized + directed scoreboard bench for fifo_downsize_sequencer (16-bit words, ratio 2).
module tb_fifo_downsize_sequencer;

  localparam int W = 16;
  localparam int R = 2;
  localparam int N = W / R;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         fifo_empty_i;
  logic [W-1:0] fifo_rd_data_i;
  logic         fifo_read_o;
  logic [N-1:0] out_data_o;
  logic         out_valid_o;
  logic         out_ready_i;
  logic         out_last_o;

  always #5 clk = ~clk;

  fifo_downsize_sequencer #(.WIDE_WIDTH(W), .RATIO(R), .NARROW_WIDTH(N)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_rd_data_i (fifo_rd_data_i),
    .fifo_read_o    (fifo_read_o),
    .out_data_o     (out_data_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_last_o     (out_last_o)
  );

  typedef struct {
    logic [N-1:0] d;
    logic         l;
  } sub_t;

  sub_t         exp_q[$];   // slices owed to the consumer, in order
  logic [W-1:0] fq[$];      // contents of the modelled FIFO

  int   errors = 0;
  int   checks = 0;
  bit   pop_seen = 1'b0;
  bit   prev_reset = 1'b1;
  bit   prev_stall = 1'b0;
  logic [N-1:0] prev_d = '0;
  logic         prev_l = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void refresh();
    fifo_empty_i   = (fq.size() == 0);
    fifo_rd_data_i = (fq.size() != 0) ? fq[0] : '0;
  endfunction

  task automatic push(input logic [W-1:0] w);
    fq.push_back(w);
    refresh();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      if (pop_seen && fq.size() != 0) void'(fq.pop_front());
      #1;
      refresh();
    end
  endtask

  // Monitor: inputs are stable at the falling edge, so this sees what the next rising edge will act on.
  always @(negedge clk) begin
    bit   exp_pop;
    sub_t s;
    if (reset_i) begin
      chk("read_in_reset", {31'd0, fifo_read_o}, 32'd0);
      exp_q.delete();
      if (prev_reset) begin
        chk("valid_in_reset", {31'd0, out_valid_o}, 32'd0);
        chk("last_in_reset", {31'd0, out_last_o}, 32'd0);
        chk("data_in_reset", {24'd0, out_data_o}, 32'd0);
      end
    end else begin
      exp_pop = (fq.size() != 0) &&
                ((exp_q.size() == 0) || (exp_q.size() == 1 && out_ready_i));
      chk("valid", {31'd0, out_valid_o}, {31'd0, exp_q.size() != 0});
      chk("pop", {31'd0, fifo_read_o}, {31'd0, exp_pop});
      if (prev_stall) begin
        chk("stall_data", {24'd0, out_data_o}, {24'd0, prev_d});
        chk("stall_last", {31'd0, out_last_o}, {31'd0, prev_l});
      end
      if (out_valid_o && out_ready_i && exp_q.size() != 0) begin
        s = exp_q.pop_front();
        chk("data", {24'd0, out_data_o}, {24'd0, s.d});
        chk("last", {31'd0, out_last_o}, {31'd0, s.l});
      end
      if (fifo_read_o && fq.size() != 0) begin
        for (int i = 0; i < R; i++) begin
          s.d = fq[0][i*N +: N];
          s.l = (i == R - 1);
          exp_q.push_back(s);
        end
      end
    end
    pop_seen   = fifo_read_o && !reset_i;
    prev_stall = !reset_i && out_valid_o && !out_ready_i;
    prev_d     = out_data_o;
    prev_l     = out_last_o;
    prev_reset = reset_i;
  end

  initial begin
    reset_i     = 1'b1;
    out_ready_i = 1'b1;
    refresh();

    // Reset held with a word waiting: nothing may pop until release.
    push(16'hBEEF);
    step(2);
    reset_i = 1'b0;
    step(4);

    // Single word, consumer always ready.
    push(16'hA5C3);
    step(4);

    // Backpressure on the first slice.
    push(16'hA5C3);
    out_ready_i = 1'b0;
    step(4);
    out_ready_i = 1'b1;
    step(3);

    // Back-to-back words with no bubble.
    push(16'h1122);
    push(16'h3344);
    step(6);

    // Reset after the first slice is accepted.
    push(16'hA5C3);
    step(2);
    reset_i = 1'b1;
    step(1);
    reset_i = 1'b0;
    step(3);

    // Empty at the last slice, then a late arrival.
    push(16'h5A3C);
    step(5);
    push(16'h0FF0);
    step(4);

    // Random traffic with occasional reset.
    for (int c = 0; c < 600; c++) begin
      if (fq.size() < 4 && ($urandom_range(0, 2) != 0)) push(W'($urandom));
      out_ready_i = ($urandom_range(0, 3) != 0);
      reset_i     = ($urandom_range(0, 99) == 0);
      step(1);
    end

    reset_i     = 1'b0;
    out_ready_i = 1'b1;
    step(20);
    chk("drain_exp", exp_q.size(), 32'd0);
    chk("drain_fifo", fq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
